// File: rtl/fpga_div_pkg.sv
// Shared constants and FSM state type for the restoring divider.
package fpga_div_pkg;

    localparam int unsigned DIV_W     = 35;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/fpga_divider_if.sv
// Request/result handshake bundle between a requester (master) and the divider (slave).
interface fpga_divider_if #(
    parameter int unsigned W = fpga_div_pkg::DIV_W
);

    logic [2*W-1:0] DIV_nn_a0;
    logic [W-1:0]   DIV_dd_a0;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   DIV_qq;
    logic [W-1:0]   DIV_rr;
    logic           DIV_err;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output DIV_nn_a0, DIV_dd_a0, in_valid, out_ready,
        input  in_ready, DIV_qq, DIV_rr, DIV_err, out_valid
    );

    modport slave (
        input  DIV_nn_a0, DIV_dd_a0, in_valid, out_ready,
        output in_ready, DIV_qq, DIV_rr, DIV_err, out_valid
    );

endinterface

// File: rtl/fpga_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module fpga_div_step #(
    parameter int unsigned W = fpga_div_pkg::DIV_W
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_dd,
    output logic [W:0]   o_rem,
    output logic         o_qbit
);

    localparam int unsigned RW = W + 1;
    localparam int unsigned XW = W + 2;

    logic [XW-1:0] w_shift;
    logic [XW-1:0] w_dd_x;

    // Extra headroom bit so the shifted value is never truncated before the compare.
    assign w_shift = {i_rem, i_bit};
    assign w_dd_x  = {2'b00, i_dd};
    assign o_qbit  = (w_shift >= w_dd_x);
    assign o_rem   = o_qbit ? RW'(w_shift - w_dd_x) : RW'(w_shift);

endmodule

// File: rtl/fpga_divider.sv
// Sequential 2W/W restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_OVF_CHECK_EN to flag divide-by-zero / quotient overflow at accept and skip RUN.
module fpga_divider #(
    parameter int unsigned W = fpga_div_pkg::DIV_W
) (
    input  logic          clk,
    input  logic          reset,
    fpga_divider_if.slave div_bus
);

    import fpga_div_pkg::*;

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [W:0]       r_rem;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_dd;
    logic [W-1:0]     r_qq;
    logic [W-1:0]     r_rr;
    logic             r_err;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_ovf;
    logic             w_qbit;
    logic [W:0]       w_rem_nxt;
    logic [W-1:0]     w_lo_nxt;

    assign w_accept = r_in_ready && div_bus.in_valid;

`ifdef DIV_OVF_CHECK_EN
    assign w_ovf = (div_bus.DIV_dd_a0 == '0) ||
                   (div_bus.DIV_nn_a0[2*W-1:W] >= div_bus.DIV_dd_a0);
`else
    assign w_ovf = 1'b0;
`endif

    fpga_div_step #(.W(W)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_lo[W-1]),
        .i_dd   (r_dd),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // Low half doubles as the dividend shifter and the quotient accumulator.
    assign w_lo_nxt = {r_lo[W-2:0], w_qbit};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_ovf ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_state_nxt = ST_DONE;
            ST_DONE: if (div_bus.out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State plus handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_lo  <= '0;
            r_dd  <= '0;
            r_qq  <= '0;
            r_rr  <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dd  <= div_bus.DIV_dd_a0;
                        r_lo  <= div_bus.DIV_nn_a0[W-1:0];
                        r_rem <= {1'b0, div_bus.DIV_nn_a0[2*W-1:W]};
                        r_cnt <= CNT_W'(W - 1);
                        r_err <= w_ovf;
                        if (w_ovf) begin
                            r_qq <= '1;
                            r_rr <= div_bus.DIV_nn_a0[W-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_lo  <= w_lo_nxt;
                    if (r_cnt == '0) begin
                        r_qq <= w_lo_nxt;
                        r_rr <= w_rem_nxt[W-1:0];
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_bus.in_ready  = r_in_ready;
    assign div_bus.out_valid = r_out_valid;
    assign div_bus.DIV_qq    = r_qq;
    assign div_bus.DIV_rr    = r_rr;
    assign div_bus.DIV_err   = r_err;

endmodule

// File: tb/tb_fpga_divider.sv
// Directed self-checking bench for fpga_divider (W=35), immediate-assertion style.
module tb_fpga_divider;

    localparam int unsigned W = 35;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    fpga_divider_if #(.W(W)) bus ();

    fpga_divider #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .div_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2*W-1:0] nn, input logic [W-1:0] dd);
        bus.DIV_nn_a0 = nn;
        bus.DIV_dd_a0 = dd;
    endtask

    // Latency counts rising edges with the accepting edge itself as edge 1.
    task automatic run_req(input logic [2*W-1:0] nn, input logic [W-1:0] dd, output int lat);
        drive(nn, dd);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 80'(bus.out_valid), 80'(0));
        check({tag, "_in_ready"},   80'(bus.in_ready),  80'(1));
    endtask

    initial begin
        int   lat;
        logic acc;
        int   idx_in, idx_out, last_out;
        logic [2*W-1:0] nn_v [4];
        logic [W-1:0]   dd_v [4];
        logic [W-1:0]   q_v  [4];
        logic [W-1:0]   r_v  [4];

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive('0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 80'(bus.out_valid), 80'(0));
        check("rst_qq",        80'(bus.DIV_qq),    80'(0));
        check("rst_rr",        80'(bus.DIV_rr),    80'(0));
        check("rst_err",       80'(bus.DIV_err),   80'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  80'(bus.in_ready),  80'(1));

        // Exact division
        run_req(70'h2B8CFFED63, 35'h7ADEF, lat);
        check("a_lat",      80'(lat),          80'(36));
        check("a_qq",       80'(bus.DIV_qq),   80'h5ABCD);
        check("a_rr",       80'(bus.DIV_rr),   80'h0);
        check("a_err",      80'(bus.DIV_err),  80'(0));
        check("a_in_ready", 80'(bus.in_ready), 80'(0));
        take("a");

        // Nonzero remainder
        run_req(70'h2B8CFFED68, 35'h7ADEF, lat);
        check("b_lat", 80'(lat),         80'(36));
        check("b_qq",  80'(bus.DIV_qq),  80'h5ABCD);
        check("b_rr",  80'(bus.DIV_rr),  80'h5);
        check("b_err", 80'(bus.DIV_err), 80'(0));
        take("b");

        // Back-pressure: hold DONE for 10 cycles with a competing request present
        run_req(70'h2B8CFFED63, 35'h7ADEF, lat);
        check("c_lat", 80'(lat), 80'(36));
        drive(70'h64, 35'h7);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("c_hold_valid", 80'(bus.out_valid), 80'(1));
            check("c_hold_ready", 80'(bus.in_ready),  80'(0));
            check("c_hold_qq",    80'(bus.DIV_qq),    80'h5ABCD);
            check("c_hold_rr",    80'(bus.DIV_rr),    80'h0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("c_hs_valid", 80'(bus.out_valid), 80'(0));
        check("c_hs_ready", 80'(bus.in_ready),  80'(1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("c_quiet_valid", 80'(bus.out_valid), 80'(0));

`ifdef DIV_OVF_CHECK_EN
        run_req(70'h2B8CFFED63, 35'h0, lat);
        check("z_lat", 80'(lat),         80'(1));
        check("z_err", 80'(bus.DIV_err), 80'(1));
        check("z_qq",  80'(bus.DIV_qq),  80'h7FFFFFFFF);
        check("z_rr",  80'(bus.DIV_rr),  80'h38CFFED63);
        take("z");
        run_req(70'(35'h7ADEF) << 35, 35'h7ADEF, lat);
        check("o_lat", 80'(lat),         80'(1));
        check("o_err", 80'(bus.DIV_err), 80'(1));
        check("o_qq",  80'(bus.DIV_qq),  80'h7FFFFFFFF);
        check("o_rr",  80'(bus.DIV_rr),  80'h0);
        take("o");
`endif

        // Reset in the middle of RUN
        drive(70'h2B8CFFED63, 35'h7ADEF);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("r_out_valid", 80'(bus.out_valid), 80'(0));
        check("r_qq",        80'(bus.DIV_qq),    80'(0));
        check("r_rr",        80'(bus.DIV_rr),    80'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("r_no_residual", 80'(bus.out_valid), 80'(0));
        check("r_in_ready",    80'(bus.in_ready),  80'(1));
        run_req(70'h2B8CFFED63, 35'h7ADEF, lat);
        check("r_lat", 80'(lat),        80'(36));
        check("r_qq2", 80'(bus.DIV_qq), 80'h5ABCD);
        check("r_rr2", 80'(bus.DIV_rr), 80'h0);
        take("r");

        // Back-to-back stream with the consumer always ready
        nn_v = '{70'h2B8CFFED63, 70'h2B8CFFED68, 70'h64,  70'h7FFFFFFFE};
        dd_v = '{35'h7ADEF,      35'h7ADEF,      35'h7,   35'h3};
        q_v  = '{35'h5ABCD,      35'h5ABCD,      35'hE,   35'h2AAAAAAAA};
        r_v  = '{35'h0,          35'h5,          35'h2,   35'h0};
        idx_in   = 0;
        idx_out  = 0;
        last_out = 0;
        bus.out_ready = 1'b1;
        drive(nn_v[0], dd_v[0]);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && idx_out < 4; cyc++) begin
            acc = bus.in_ready && bus.in_valid;
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 4) drive(nn_v[idx_in], dd_v[idx_in]);
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                check("s_qq",  80'(bus.DIV_qq),  80'(q_v[idx_out]));
                check("s_rr",  80'(bus.DIV_rr),  80'(r_v[idx_out]));
                check("s_err", 80'(bus.DIV_err), 80'(0));
                if (idx_out > 0) check("s_period", 80'(cyc - last_out), 80'(W + 2));
                last_out = cyc;
                idx_out++;
            end
        end
        check("s_count", 80'(idx_out), 80'(4));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
